// File: rtl/reg_file_pkg.sv
// Shared constants and clear-controller state encoding for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NWR  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port: stored value, overridden by same-cycle writes, forced to zero for x0 or while clearing.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = 5,
  parameter int NWR  = DEF_NWR
) (
  input  logic [AW-1:0]       addr,
  input  logic                zero,
  input  logic [XLEN-1:0]     stored,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   w_addr,
  input  logic [NWR*XLEN-1:0] w_data,
  output logic [XLEN-1:0]     data
);

  always_comb begin
    data = stored;
    // Ascending scan so the highest-indexed matching write port wins.
    for (int k = 0; k < NWR; k++) begin
      if (we[k] && (w_addr[k*AW +: AW] == addr)) begin
        data = w_data[k*XLEN +: XLEN];
      end
    end
    if (zero || (addr == '0)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-to-read bypass and a sequential clear engine
// that presents an all-zero view while it walks the array.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NWR-1:0]                    we,
  input  logic [NWR*$clog2(NREG)-1:0]       w_addr,
  input  logic [NWR*XLEN-1:0]               w_data,
  input  logic [NRD*$clog2(NREG)-1:0]       r_addr,
  output logic [NRD*XLEN-1:0]               r_data,
  input  logic                              clr_req,
  output logic                              busy
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  clr_state_e      state;
  logic [AW-1:0]   cnt;

  // Clear controller: reset or clr_req starts a walk over x1..x(NREG-1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= AW'(1);
      busy  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= AW'(1);
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + AW'(1);
          if (cnt == AW'(NREG - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Unified write path: user ports 0..NWR-1 plus the clear engine as port NWR.
  logic [NWR:0]    wen;
  logic [AW-1:0]   wadr_x [NWR+1];
  logic [XLEN-1:0] wdat_x [NWR+1];

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wen[k]    = we[k] && (w_addr[k*AW +: AW] != '0) && !busy && !rst;
      wadr_x[k] = w_addr[k*AW +: AW];
      wdat_x[k] = w_data[k*XLEN +: XLEN];
    end
    wen[NWR]    = busy && !rst;
    wadr_x[NWR] = cnt;
    wdat_x[NWR] = '0;
  end

  // Later ports override earlier ones on an address collision.
  always_ff @(posedge clk) begin
    for (int k = 0; k <= NWR; k++) begin
      if (wen[k]) begin
        regs[wadr_x[k]] <= wdat_x[k];
      end
    end
  end

  logic zero_view;
  assign zero_view = rst || busy;

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [XLEN-1:0] stored;
    assign stored = regs[r_addr[j*AW +: AW]];

    reg_file_rd_port #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_rd (
      .addr   (r_addr[j*AW +: AW]),
      .zero   (zero_view),
      .stored (stored),
      .we     (we),
      .w_addr (w_addr),
      .w_data (w_data),
      .data   (r_data[j*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic against an array model.
module tb_reg_file_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clr_req;
  logic [NWR-1:0]       we;
  logic [NWR*AW-1:0]    w_addr;
  logic [NWR*XLEN-1:0]  w_data;
  logic [NRD*AW-1:0]    r_addr;
  logic [NRD*XLEN-1:0]  r_data;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] mem [NREG];
  int              clr_left = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .r_addr  (r_addr),
    .r_data  (r_data),
    .clr_req (clr_req),
    .busy    (busy)
  );

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    logic [XLEN-1:0] v;
    if (rst || clr_left > 0 || a == 0) return '0;
    v = mem[a];
    for (int k = 0; k < NWR; k++)
      if (we[k] && w_addr[k*AW +: AW] == a) v = w_data[k*XLEN +: XLEN];
    return v;
  endfunction

  // Advance the model by one edge using the inputs currently applied, then clock the DUT.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] = '0;
      clr_left = NREG - 1;
    end else if (clr_left > 0) begin
      clr_left--;
    end else begin
      for (int k = 0; k < NWR; k++)
        if (we[k] && w_addr[k*AW +: AW] != 0) mem[w_addr[k*AW +: AW]] = w_data[k*XLEN +: XLEN];
      if (clr_req) begin
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        clr_left = NREG - 1;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; clr_req = 1'b0; we = '0; w_addr = '0; w_data = '0;
    r_addr = 10'($urandom);
    step();
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy_during_rst: got %b expected 1", busy); end
    for (int j = 0; j < NRD; j++) begin
      checks++;
      if (r_data[j*XLEN +: XLEN] !== '0)
        begin errors++; $display("FAIL reset_rdata_during_rst port %0d: got %h expected 0", j, r_data[j*XLEN +: XLEN]); end
    end
    step();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      r_addr = 10'($urandom);
      #1;
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (r_data[j*XLEN +: XLEN] !== '0)
          begin errors++; $display("FAIL reset_rdata_busy port %0d: got %h expected 0", j, r_data[j*XLEN +: XLEN]); end
      end
      n++;
      step();
    end
    checks++;
    if (n != NREG - 1) begin errors++; $display("FAIL reset_busy_len: got %0d expected %0d", n, NREG - 1); end
    r_addr[0 +: AW] = 5'd5;
    #1;
    checks++;
    if (r_data[0 +: XLEN] !== 32'h0) begin errors++; $display("FAIL reset_read_x5: got %h expected 0", r_data[0 +: XLEN]); end
  endtask

  task automatic test_bypass();
    we = 2'b01; w_addr[0 +: AW] = 5'd7; w_data[0 +: XLEN] = 32'hDEADBEEF;
    r_addr[AW +: AW] = 5'd7;
    #1;
    checks++;
    if (r_data[XLEN +: XLEN] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", r_data[XLEN +: XLEN]); end
    step();
    we = '0;
    #1;
    checks++;
    if (r_data[XLEN +: XLEN] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL bypass_next_cycle: got %h expected deadbeef", r_data[XLEN +: XLEN]); end
  endtask

  task automatic test_conflict();
    we = 2'b11;
    w_addr = {5'd9, 5'd9};
    w_data = {32'h2222, 32'h1111};
    r_addr = {5'd9, 5'd9};
    #1;
    for (int j = 0; j < NRD; j++) begin
      checks++;
      if (r_data[j*XLEN +: XLEN] !== 32'h2222)
        begin errors++; $display("FAIL conflict_comb port %0d: got %h expected 2222", j, r_data[j*XLEN +: XLEN]); end
    end
    step();
    we = '0;
    #1;
    for (int j = 0; j < NRD; j++) begin
      checks++;
      if (r_data[j*XLEN +: XLEN] !== 32'h2222)
        begin errors++; $display("FAIL conflict_stored port %0d: got %h expected 2222", j, r_data[j*XLEN +: XLEN]); end
    end
  endtask

  task automatic test_x0();
    we = 2'b10;
    w_addr[AW +: AW] = 5'd0;
    w_data[XLEN +: XLEN] = 32'hFFFFFFFF;
    r_addr = '0;
    #1;
    checks++;
    if (r_data[0 +: XLEN] !== 32'h0) begin errors++; $display("FAIL x0_comb: got %h expected 0", r_data[0 +: XLEN]); end
    step();
    we = '0;
    #1;
    checks++;
    if (r_data[XLEN +: XLEN] !== 32'h0) begin errors++; $display("FAIL x0_next: got %h expected 0", r_data[XLEN +: XLEN]); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 1; i < NREG; i += 2) begin
      we[0] = 1'b1; w_addr[0 +: AW] = AW'(i); w_data[0 +: XLEN] = XLEN'(i);
      we[1] = (i + 1 < NREG); w_addr[AW +: AW] = AW'(i + 1); w_data[XLEN +: XLEN] = XLEN'(i + 1);
      step();
    end
    we = '0;
    r_addr = {5'd30, 5'd3};
    #1;
    checks++;
    if (r_data[0 +: XLEN] !== 32'd3) begin errors++; $display("FAIL clear_fill_x3: got %h expected 3", r_data[0 +: XLEN]); end
    checks++;
    if (r_data[XLEN +: XLEN] !== 32'd30) begin errors++; $display("FAIL clear_fill_x30: got %h expected 1e", r_data[XLEN +: XLEN]); end
    // A write coincident with clr_req commits and is then wiped.
    clr_req = 1'b1; we = 2'b01; w_addr[0 +: AW] = 5'd12; w_data[0 +: XLEN] = 32'hABCD;
    step();
    clr_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      we = 2'($urandom); w_addr = 10'($urandom); w_data = 64'({$urandom, $urandom});
      clr_req = 1'($urandom); r_addr = 10'($urandom);
      #1;
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (r_data[j*XLEN +: XLEN] !== '0)
          begin errors++; $display("FAIL clear_busy_read port %0d: got %h expected 0", j, r_data[j*XLEN +: XLEN]); end
      end
      n++;
      step();
    end
    clr_req = 1'b0; we = '0;
    checks++;
    if (n != NREG - 1) begin errors++; $display("FAIL clear_busy_len: got %0d expected %0d", n, NREG - 1); end
    for (int i = 0; i < NREG; i++) begin
      r_addr = {AW'(NREG - 1 - i), AW'(i)};
      #1;
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (r_data[j*XLEN +: XLEN] !== '0)
          begin errors++; $display("FAIL clear_after x%0d port %0d: got %h expected 0", r_addr[j*AW +: AW], j, r_data[j*XLEN +: XLEN]); end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    we = '0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midclr_busy cycle %0d: got %b expected 1", i, busy); end
      step();
    end
    rst = 1'b1;
    r_addr = 10'($urandom);
    #1;
    checks++;
    if (r_data !== '0) begin errors++; $display("FAIL midclr_rdata_rst: got %h expected 0", r_data); end
    step();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n != NREG - 1) begin errors++; $display("FAIL midclr_busy_len: got %0d expected %0d", n, NREG - 1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 149) == 0);
      clr_req = ($urandom_range(0, 59) == 0);
      we      = 2'($urandom);
      for (int k = 0; k < NWR; k++) w_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      w_data  = 64'({$urandom, $urandom});
      for (int j = 0; j < NRD; j++)
        r_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      #1;
      checks++;
      if (busy !== (clr_left > 0))
        begin errors++; $display("FAIL random_busy cycle %0d: got %b expected %b", c, busy, clr_left > 0); end
      for (int j = 0; j < NRD; j++) begin
        checks++;
        if (r_data[j*XLEN +: XLEN] !== exp_read(r_addr[j*AW +: AW]))
          begin errors++; $display("FAIL random_read cycle %0d port %0d addr %0d: got %h expected %h", c, j, r_addr[j*AW +: AW], r_data[j*XLEN +: XLEN], exp_read(r_addr[j*AW +: AW])); end
      end
      step();
    end
    rst = 1'b0; clr_req = 1'b0; we = '0;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0; we = '0; w_addr = '0; w_data = '0; r_addr = '0;
    test_reset();
    test_bypass();
    test_conflict();
    test_x0();
    test_clear();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
